// File: rtl/imem_access_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Package : imem_ctrl_pkg
// Brief   : Shared types and constants for the instruction-memory access controller.
// Revision: 1.0
// =============================================================================
package imem_ctrl_pkg;

    localparam int   BPW       = 4;
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LD    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } state_t;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_access_ctrl_if.sv
`default_nettype none
// =============================================================================
// Interface : imem_access_ctrl_if
// Brief     : Fetch, loader and byte-wide memory signals of the access controller.
// Revision  : 1.0
// =============================================================================
interface imem_access_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ack;
    logic [31:0]       fetch_rdata;
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
        output fetch_ack, fetch_rdata, ld_ack, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
        input  fetch_ack, fetch_rdata, ld_ack, busy, mem_addr, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/imem_access_ctrl_arb2.sv
`default_nettype none
// =============================================================================
// Module  : imem_arb2
// Brief   : Two-requester one-hot arbiter; loader priority, or round-robin
//           when IMEM_ARB_RR_EN is defined.
// Revision: 1.0
// =============================================================================
module imem_arb2
    import imem_ctrl_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       en,
`ifdef IMEM_ARB_RR_EN
    input  wire logic       last,
`endif
    output logic      [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
`ifdef IMEM_ARB_RR_EN
            // On contention the requester that was not served last wins.
            if (req[REQ_LD] && req[REQ_FETCH]) begin
                if (last == REQ_LD) begin
                    gnt[REQ_FETCH] = 1'b1;
                end else begin
                    gnt[REQ_LD] = 1'b1;
                end
            end else begin
                gnt = req;
            end
`else
            if (req[REQ_LD]) begin
                gnt[REQ_LD] = 1'b1;
            end else if (req[REQ_FETCH]) begin
                gnt[REQ_FETCH] = 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_access_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : imem_access_ctrl
// Brief   : Shares a byte-wide instruction memory between fetch (word reads)
//           and loader (word writes); optional macro IMEM_ARB_RR_EN.
// Revision: 1.0
// =============================================================================
module imem_access_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    imem_access_ctrl_if.slave bus
);

    localparam logic [1:0] c_last_k = 2'(BPW - 1);

    state_t            r_state;
    logic [1:0]        r_k;
    logic [ADDR_W-3:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic              r_we;
`ifdef IMEM_ARB_RR_EN
    logic              r_last;
`endif
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [1:0]        w_k_nx;
    logic [31:0]       w_word;
    logic              w_unused;

    assign w_unused = ^{bus.fetch_addr[31:ADDR_W], bus.fetch_addr[1:0],
                        bus.ld_addr[31:ADDR_W], bus.ld_addr[1:0]};
    assign w_k_nx   = r_k + 2'd1;

    // Reset kills the in-flight byte write in the same cycle it is raised.
    assign bus.mem_we = r_we & ~rst;

    always_comb begin
        w_req            = 2'b00;
        w_req[REQ_FETCH] = bus.fetch_req;
        w_req[REQ_LD]    = bus.ld_req;
    end

    always_comb begin
        w_word = r_word;
        w_word[{r_k, 3'b000} +: 8] = bus.mem_rdata;
    end

    imem_arb2 u_arb (
        .req  (w_req),
        .en   (r_state == IDLE),
`ifdef IMEM_ARB_RR_EN
        .last (r_last),
`endif
        .gnt  (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_k             <= 2'd0;
            r_base          <= '0;
            r_wdata         <= '0;
            r_word          <= '0;
            r_we            <= 1'b0;
            bus.fetch_ack   <= 1'b0;
            bus.ld_ack      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.fetch_rdata <= '0;
`ifdef IMEM_ARB_RR_EN
            r_last          <= REQ_FETCH;
`endif
        end else begin
            bus.fetch_ack <= 1'b0;
            bus.ld_ack    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_k <= 2'd0;
                    if (w_gnt[REQ_LD]) begin
                        r_base        <= bus.ld_addr[ADDR_W-1:2];
                        r_wdata       <= bus.ld_wdata;
                        bus.mem_addr  <= {bus.ld_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_wdata <= bus.ld_wdata[7:0];
                        r_we          <= 1'b1;
                        bus.busy      <= 1'b1;
                        r_state       <= WR;
`ifdef IMEM_ARB_RR_EN
                        r_last        <= REQ_LD;
`endif
                    end else if (w_gnt[REQ_FETCH]) begin
                        r_base        <= bus.fetch_addr[ADDR_W-1:2];
                        bus.mem_addr  <= {bus.fetch_addr[ADDR_W-1:2], 2'b00};
                        bus.busy      <= 1'b1;
                        r_state       <= RD;
`ifdef IMEM_ARB_RR_EN
                        r_last        <= REQ_FETCH;
`endif
                    end
                end
                RD: begin
                    r_word <= w_word;
                    if (r_k == c_last_k) begin
                        bus.fetch_rdata <= w_word;
                        bus.fetch_ack   <= 1'b1;
                        r_state         <= ACK;
                    end else begin
                        r_k          <= w_k_nx;
                        bus.mem_addr <= {r_base, w_k_nx};
                    end
                end
                WR: begin
                    if (r_k == c_last_k) begin
                        r_we       <= 1'b0;
                        bus.ld_ack <= 1'b1;
                        r_state    <= ACK;
                    end else begin
                        r_k           <= w_k_nx;
                        bus.mem_addr  <= {r_base, w_k_nx};
                        bus.mem_wdata <= byte_lane(r_wdata, w_k_nx);
                    end
                end
                ACK: begin
                    bus.busy <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_access_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_imem_access_ctrl
// Brief   : Self-checking bench for imem_access_ctrl with a byte-array memory
//           and a word-level reference image of its contents.
// Revision: 1.0
// =============================================================================
module tb_imem_access_ctrl;

    logic clk;
    logic rst;
    int   vec;
    int   errs;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    imem_access_ctrl_if #(.ADDR_W(16)) bus ();

    imem_access_ctrl #(.ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bd_we)      mem[bd_addr]      <= bd_data;
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'({a[15:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [63:0] exp_seq(input logic [31:0] a);
        logic [15:0] b;
        b = {a[15:2], 2'b00};
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] w);
        int b;
        b = int'({a[15:2], 2'b00});
        for (int i = 0; i < 4; i++) ref_mem[b+i] = w[8*i +: 8];
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 16'(a); bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one request and observes it until ack (cycle 0 = request sampled in IDLE).
    task automatic do_op(input bit is_ld, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output logic [63:0] aseq,
                         output logic [31:0] wseq, output int we_cnt);
        lat = -1; rd = '0; aseq = '0; wseq = '0; we_cnt = 0;
        @(posedge clk); #1;
        if (is_ld) begin
            bus.ld_req = 1'b1; bus.ld_addr = addr; bus.ld_wdata = wdata;
        end else begin
            bus.fetch_req = 1'b1; bus.fetch_addr = addr;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (n >= 1 && n <= 4) begin
                aseq[16*(n-1) +: 16] = bus.mem_addr;
                wseq[8*(n-1) +: 8]   = bus.mem_wdata;
            end
            if (is_ld ? bus.ld_ack : bus.fetch_ack) begin
                lat = n;
                rd  = bus.fetch_rdata;
                break;
            end
        end
        bus.ld_req = 1'b0; bus.fetch_req = 1'b0;
    endtask

    task automatic contend(input logic [31:0] fa, input logic [31:0] la, input logic [31:0] wd,
                           output int fl, output int ll, output logic [31:0] rd);
        fl = -1; ll = -1; rd = '0;
        @(posedge clk); #1;
        bus.fetch_req = 1'b1; bus.fetch_addr = fa;
        bus.ld_req = 1'b1; bus.ld_addr = la; bus.ld_wdata = wd;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.fetch_ack) begin fl = n; rd = bus.fetch_rdata; bus.fetch_req = 1'b0; end
            if (bus.ld_ack)    begin ll = n; bus.ld_req = 1'b0; end
            if (fl >= 0 && ll >= 0) break;
        end
        bus.fetch_req = 1'b0; bus.ld_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vec++; if (bus.busy !== 1'b0)        begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vec++; if (bus.fetch_ack !== 1'b0)   begin errs++; $display("FAIL reset_fetch_ack: got %b want 0", bus.fetch_ack); end
        vec++; if (bus.ld_ack !== 1'b0)      begin errs++; $display("FAIL reset_ld_ack: got %b want 0", bus.ld_ack); end
        vec++; if (bus.mem_we !== 1'b0)      begin errs++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        vec++; if (bus.mem_addr !== 16'h0)   begin errs++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
        vec++; if (bus.mem_wdata !== 8'h0)   begin errs++; $display("FAIL reset_mem_wdata: got %h want 00", bus.mem_wdata); end
        vec++; if (bus.fetch_rdata !== 32'h0) begin errs++; $display("FAIL reset_fetch_rdata: got %h want 0", bus.fetch_rdata); end
    endtask

    task automatic test_fetch();
        int lat, wc; logic [31:0] rd, ws; logic [63:0] as;
        poke(16'h40, 8'h13); poke(16'h41, 8'h05); poke(16'h42, 8'h10); poke(16'h43, 8'h00);
        do_op(1'b0, 32'h0000_0042, 32'h0, lat, rd, as, ws, wc);
        vec++; if (lat != 5)            begin errs++; $display("FAIL fetch_latency: got %0d want 5", lat); end
        vec++; if (rd !== 32'h00100513) begin errs++; $display("FAIL fetch_rdata: got %h want 00100513", rd); end
        vec++; if (as !== exp_seq(32'h40)) begin errs++; $display("FAIL fetch_addr_seq: got %h want %h", as, exp_seq(32'h40)); end
        vec++; if (wc != 0)             begin errs++; $display("FAIL fetch_mem_we: got %0d want 0", wc); end
    endtask

    task automatic test_load();
        int lat, wc; logic [31:0] rd, ws, prev; logic [63:0] as;
        prev = bus.fetch_rdata;
        do_op(1'b1, 32'h0000_0100, 32'hDEADBEEF, lat, rd, as, ws, wc);
        ref_store(32'h100, 32'hDEADBEEF);
        vec++; if (lat != 5)             begin errs++; $display("FAIL load_latency: got %0d want 5", lat); end
        vec++; if (wc != 4)              begin errs++; $display("FAIL load_we_cycles: got %0d want 4", wc); end
        vec++; if (ws !== 32'hDEADBEEF)  begin errs++; $display("FAIL load_wdata_seq: got %h want deadbeef", ws); end
        vec++; if (as !== exp_seq(32'h100)) begin errs++; $display("FAIL load_addr_seq: got %h want %h", as, exp_seq(32'h100)); end
        vec++; if (rd !== prev)          begin errs++; $display("FAIL rdata_hold: got %h want %h", rd, prev); end
        @(negedge clk);
        vec++; if ({mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} !== 32'hDEADBEEF) begin
            errs++; $display("FAIL load_mem: got %h want deadbeef", {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]});
        end
        do_op(1'b0, 32'h0000_0100, 32'h0, lat, rd, as, ws, wc);
        vec++; if (rd !== 32'hDEADBEEF)  begin errs++; $display("FAIL load_readback: got %h want deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int acks, idle; int ackc [3]; logic [31:0] exp;
        for (int i = 0; i < 12; i++) poke(i, 8'($urandom));
        acks = 0; idle = 0; ackc[0] = -1; ackc[1] = -1; ackc[2] = -1;
        @(posedge clk); #1;
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (acks >= 1 && !bus.busy) idle++;
            if (bus.fetch_ack) begin
                ackc[acks] = n;
                exp = ref_word(32'(4 * acks));
                vec++; if (bus.fetch_rdata !== exp) begin errs++; $display("FAIL b2b_rdata%0d: got %h want %h", acks, bus.fetch_rdata, exp); end
                acks++;
                if (acks == 3) break;
                bus.fetch_addr = 32'(4 * acks);
            end
        end
        bus.fetch_req = 1'b0;
        vec++; if (ackc[0] != 5)  begin errs++; $display("FAIL b2b_ack0: got %0d want 5", ackc[0]); end
        vec++; if (ackc[1] != 11) begin errs++; $display("FAIL b2b_ack1: got %0d want 11", ackc[1]); end
        vec++; if (ackc[2] != 17) begin errs++; $display("FAIL b2b_ack2: got %0d want 17", ackc[2]); end
        vec++; if (idle != 2)     begin errs++; $display("FAIL b2b_idle_cycles: got %0d want 2", idle); end
    endtask

    task automatic test_alias();
        int lat, wc; logic [31:0] rd, rd2, ws; logic [63:0] as;
        do_op(1'b0, 32'h0000_0004, 32'h0, lat, rd, as, ws, wc);
        do_op(1'b0, 32'h0001_0004, 32'h0, lat, rd2, as, ws, wc);
        vec++; if (rd !== ref_word(32'h4))  begin errs++; $display("FAIL alias_base: got %h want %h", rd, ref_word(32'h4)); end
        vec++; if (rd2 !== ref_word(32'h4)) begin errs++; $display("FAIL alias_rdata: got %h want %h", rd2, ref_word(32'h4)); end
        vec++; if (as !== {16'h7, 16'h6, 16'h5, 16'h4}) begin errs++; $display("FAIL alias_addr_seq: got %h want 0007000600050004", as); end
        vec++; if (lat != 5) begin errs++; $display("FAIL alias_latency: got %0d want 5", lat); end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        int lat, wc, idx; bit is_ld; logic [31:0] a, wd, rd, ws, exp; logic [63:0] as;
        for (int i = 0; i < 6; i++) begin
            pool[i] = 32'h2000 + 32'(i * 64) + 32'($urandom_range(0, 15) * 4);
            for (int j = 0; j < 4; j++) poke(int'(pool[i]) + j, 8'($urandom));
        end
        for (int t = 0; t < 16; t++) begin
            idx   = int'($urandom_range(0, 5));
            is_ld = 1'($urandom);
            a     = {16'($urandom), pool[idx][15:2], 2'($urandom)};
            wd    = $urandom;
            exp   = ref_word(a);
            do_op(is_ld, a, wd, lat, rd, as, ws, wc);
            vec++; if (lat != 5) begin errs++; $display("FAIL rand%0d_latency: got %0d want 5", t, lat); end
            vec++; if (as !== exp_seq(a)) begin errs++; $display("FAIL rand%0d_addr_seq: got %h want %h", t, as, exp_seq(a)); end
            if (is_ld) begin
                ref_store(a, wd);
                vec++; if (ws !== wd || wc != 4) begin errs++; $display("FAIL rand%0d_write: got %h/%0d want %h/4", t, ws, wc, wd); end
            end else begin
                vec++; if (rd !== exp) begin errs++; $display("FAIL rand%0d_read: got %h want %h", t, rd, exp); end
            end
        end
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] old, wd; int acks;
        for (int j = 0; j < 4; j++) poke(16'h500 + j, 8'($urandom));
        old = ref_word(32'h500);
        wd  = ~old;
        @(posedge clk); #1;
        bus.ld_req = 1'b1; bus.ld_addr = 32'h500; bus.ld_wdata = wd;
        repeat (4) @(negedge clk);
        vec++; if (bus.mem_addr !== 16'h0502 || bus.mem_we !== 1'b1) begin
            errs++; $display("FAIL midwr_k2: got %h/%b want 0502/1", bus.mem_addr, bus.mem_we);
        end
        rst = 1'b1; bus.ld_req = 1'b0;
        @(negedge clk);
        vec++; if (bus.busy !== 1'b0 || bus.ld_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
            errs++; $display("FAIL midwr_abort: got busy=%b ack=%b we=%b want 0/0/0", bus.busy, bus.ld_ack, bus.mem_we);
        end
        rst = 1'b0;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.ld_ack) acks++;
        end
        vec++; if (acks != 0) begin errs++; $display("FAIL midwr_no_ack: got %0d want 0", acks); end
        ref_mem[16'h500] = wd[7:0];
        ref_mem[16'h501] = wd[15:8];
        vec++; if ({mem[16'h503], mem[16'h502], mem[16'h501], mem[16'h500]} !== ref_word(32'h500)) begin
            errs++; $display("FAIL midwr_mem: got %h want %h", {mem[16'h503], mem[16'h502], mem[16'h501], mem[16'h500]}, ref_word(32'h500));
        end
    endtask

    task automatic test_contention();
        int fl, ll, lat, wc; logic [31:0] rd, exp, wd, ws; logic [63:0] as;
        for (int j = 0; j < 4; j++) poke(16'h200 + j, 8'($urandom));
        do_reset();
        wd  = $urandom;
        exp = ref_word(32'h200);
        contend(32'h200, 32'h300, wd, fl, ll, rd);
        ref_store(32'h300, wd);
        vec++; if (ll != 5)   begin errs++; $display("FAIL cont1_ld_ack: got %0d want 5", ll); end
        vec++; if (fl != 11)  begin errs++; $display("FAIL cont1_fetch_ack: got %0d want 11", fl); end
        vec++; if (rd !== exp) begin errs++; $display("FAIL cont1_rdata: got %h want %h", rd, exp); end
        // A lone load leaves the loader as the last-served requester.
        do_op(1'b1, 32'h304, 32'h0BADF00D, lat, rd, as, ws, wc);
        ref_store(32'h304, 32'h0BADF00D);
        wd  = $urandom;
        exp = ref_word(32'h300);
        contend(32'h300, 32'h200, wd, fl, ll, rd);
        ref_store(32'h200, wd);
`ifdef IMEM_ARB_RR_EN
        vec++; if (fl != 5)  begin errs++; $display("FAIL cont2_fetch_ack: got %0d want 5", fl); end
        vec++; if (ll != 11) begin errs++; $display("FAIL cont2_ld_ack: got %0d want 11", ll); end
`else
        vec++; if (ll != 5)  begin errs++; $display("FAIL cont2_ld_ack: got %0d want 5", ll); end
        vec++; if (fl != 11) begin errs++; $display("FAIL cont2_fetch_ack: got %0d want 11", fl); end
`endif
        vec++; if (rd !== exp) begin errs++; $display("FAIL cont2_rdata: got %h want %h", rd, exp); end
    endtask

    initial begin
        vec = 0; errs = 0;
        rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
        test_reset();
        test_fetch();
        test_load();
        test_back_to_back();
        test_alias();
        test_random();
        test_reset_midwrite();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
